// File: rtl/caminho_dados_param.sv
`default_nettype none
// ---------------------------------------------------------------------------
// caminho_dados_param : parameterised CPU datapath (ALU, register file, PC/IR,
// MAR/MDR/WDR) with a three-state memory handshake FSM.   Rev 1.0
// ---------------------------------------------------------------------------
module caminho_dados_param #(
  parameter int WIDTH = 8,
  parameter int NREGS = 4,
  localparam int RSEL = $clog2(NREGS)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [1:0]       bus1_sel,
  input  logic [1:0]       bus2_sel,
  input  logic [3:0]       alu_sel,
  input  logic [RSEL-1:0]  src_a,
  input  logic [RSEL-1:0]  src_b,
  input  logic [RSEL-1:0]  dst,
  input  logic             ld_pc,
  input  logic             pc_inc,
  input  logic             ld_ir,
  input  logic             ld_mar,
  input  logic             ld_reg,
  input  logic             ld_flags,
  input  logic             mem_rd,
  input  logic             mem_wr,
  input  logic             mem_ack,
  input  logic [WIDTH-1:0] dado_mem,
  output logic [WIDTH-1:0] endereco_mem,
  output logic [WIDTH-1:0] dado_para_mem,
  output logic             mem_req,
  output logic             mem_we,
  output logic             busy,
  output logic [WIDTH-1:0] ir_out,
  output logic [3:0]       flags_out
);

  localparam int MSB = WIDTH - 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RD   = 2'd1,
    S_WR   = 2'd2
  } state_t;

  state_t r_state, w_state_nxt;

  logic [WIDTH-1:0] r_pc, r_ir, r_mar, r_mdr, r_wdr;
  logic [WIDTH-1:0] r_regs [NREGS];
  logic [3:0]       r_flags;

  logic [WIDTH-1:0] w_a, w_b, w_bus1, w_bus2, w_pc_plus1, w_alu;
  logic [WIDTH:0]   w_ext;
  logic [WIDTH:0]   w_one;
  logic             w_c, w_v, w_busy;
  logic [3:0]       w_flags;

  assign w_a        = r_regs[src_a];
  assign w_b        = r_regs[src_b];
  assign w_pc_plus1 = r_pc + {{(WIDTH-1){1'b0}}, 1'b1};
  assign w_one      = {{WIDTH{1'b0}}, 1'b1};

  always_comb begin
    w_bus1 = r_pc;
    case (bus1_sel)
      2'd0:    w_bus1 = r_pc;
      2'd1:    w_bus1 = w_a;
      2'd2:    w_bus1 = w_b;
      default: w_bus1 = r_mdr;
    endcase
  end

  always_comb begin
    w_bus2 = w_alu;
    case (bus2_sel)
      2'd0:    w_bus2 = w_alu;
      2'd1:    w_bus2 = w_bus1;
      2'd2:    w_bus2 = r_mdr;
      default: w_bus2 = w_pc_plus1;
    endcase
  end

  // Carry/borrow come from the extra top bit of a WIDTH+1 bit computation.
  always_comb begin
    w_alu = w_a;
    w_ext = '0;
    w_c   = 1'b0;
    w_v   = 1'b0;
    case (alu_sel)
      4'd0: begin
        w_ext = {1'b0, w_a} + {1'b0, w_b};
        w_alu = w_ext[MSB:0];
        w_c   = w_ext[WIDTH];
        w_v   = (w_a[MSB] == w_b[MSB]) && (w_alu[MSB] != w_a[MSB]);
      end
      4'd1: begin
        w_ext = {1'b0, w_a} - {1'b0, w_b};
        w_alu = w_ext[MSB:0];
        w_c   = w_ext[WIDTH];
        w_v   = (w_a[MSB] != w_b[MSB]) && (w_alu[MSB] != w_a[MSB]);
      end
      4'd2: w_alu = w_a & w_b;
      4'd3: w_alu = w_a | w_b;
      4'd4: w_alu = w_a ^ w_b;
      4'd5: w_alu = ~w_a;
      4'd6: begin
        w_alu = {w_a[MSB-1:0], 1'b0};
        w_c   = w_a[MSB];
      end
      4'd7: begin
        w_alu = {1'b0, w_a[MSB:1]};
        w_c   = w_a[0];
      end
      4'd8: begin
        w_ext = {1'b0, w_a} + w_one;
        w_alu = w_ext[MSB:0];
        w_c   = w_ext[WIDTH];
        w_v   = !w_a[MSB] && w_alu[MSB];
      end
      4'd9: begin
        w_ext = {1'b0, w_a} - w_one;
        w_alu = w_ext[MSB:0];
        w_c   = w_ext[WIDTH];
        w_v   = w_a[MSB] && !w_alu[MSB];
      end
      default: w_alu = w_a;
    endcase
  end

  assign w_flags = {w_v, w_c, w_alu[MSB], (w_alu == '0)};

  assign w_busy = (r_state != S_IDLE);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Write wins over read when both strobes arrive together.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (mem_wr) begin
          w_state_nxt = S_WR;
        end else if (mem_rd) begin
          w_state_nxt = S_RD;
        end
      end
      S_RD:    if (mem_ack) w_state_nxt = S_IDLE;
      S_WR:    if (mem_ack) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_pc    <= '0;
      r_ir    <= '0;
      r_mar   <= '0;
      r_mdr   <= '0;
      r_wdr   <= '0;
      r_flags <= '0;
      for (int i = 0; i < NREGS; i++) begin
        r_regs[i] <= '0;
      end
    end else begin
      if (ld_pc) begin
        r_pc <= w_bus2;
      end else if (pc_inc) begin
        r_pc <= w_pc_plus1;
      end
      if (ld_ir) r_ir <= w_bus2;
      if (ld_mar && !w_busy) r_mar <= w_bus2;
      if (ld_reg) r_regs[dst] <= w_bus2;
      if (ld_flags) r_flags <= w_flags;
      if ((r_state == S_IDLE) && mem_wr) r_wdr <= w_bus1;
      if ((r_state == S_RD) && mem_ack) r_mdr <= dado_mem;
    end
  end

  assign endereco_mem  = r_mar;
  assign dado_para_mem = r_wdr;
  assign mem_req       = w_busy;
  assign mem_we        = (r_state == S_WR);
  assign busy          = w_busy;
  assign ir_out        = r_ir;
  assign flags_out     = r_flags;

endmodule
`default_nettype wire

// File: tb/tb_caminho_dados_param.sv
`default_nettype none
// tb_caminho_dados_param : directed + randomized checks of the datapath
// against an arithmetic reference model; second instance at WIDTH=16/NREGS=8.
module tb_caminho_dados_param;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic [1:0] bus1_sel, bus2_sel, src_a, src_b, dst;
  logic [3:0] alu_sel;
  logic       ld_pc, pc_inc, ld_ir, ld_mar, ld_reg, ld_flags;
  logic       mem_rd, mem_wr, mem_ack;
  logic [7:0] dado_mem, endereco_mem, dado_para_mem, ir_out;
  logic       mem_req, mem_we, busy;
  logic [3:0] flags_out;

  logic [1:0]  w_b1, w_b2;
  logic [2:0]  w_sa, w_sb, w_dst;
  logic [3:0]  w_alu;
  logic        w_ldpc, w_inc, w_ldir, w_ldmar, w_ldreg, w_ldfl, w_rd, w_wr, w_ack;
  logic [15:0] w_dm, w_addr, w_wdata, w_ir;
  logic        w_req, w_we, w_busy;
  logic [3:0]  w_flags;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clock = ~clock;

  caminho_dados_param #(.WIDTH(8), .NREGS(4)) dut (
    .clock(clock), .reset(reset), .bus1_sel(bus1_sel), .bus2_sel(bus2_sel),
    .alu_sel(alu_sel), .src_a(src_a), .src_b(src_b), .dst(dst),
    .ld_pc(ld_pc), .pc_inc(pc_inc), .ld_ir(ld_ir), .ld_mar(ld_mar),
    .ld_reg(ld_reg), .ld_flags(ld_flags), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .mem_ack(mem_ack), .dado_mem(dado_mem), .endereco_mem(endereco_mem),
    .dado_para_mem(dado_para_mem), .mem_req(mem_req), .mem_we(mem_we),
    .busy(busy), .ir_out(ir_out), .flags_out(flags_out)
  );

  caminho_dados_param #(.WIDTH(16), .NREGS(8)) dut16 (
    .clock(clock), .reset(reset), .bus1_sel(w_b1), .bus2_sel(w_b2),
    .alu_sel(w_alu), .src_a(w_sa), .src_b(w_sb), .dst(w_dst),
    .ld_pc(w_ldpc), .pc_inc(w_inc), .ld_ir(w_ldir), .ld_mar(w_ldmar),
    .ld_reg(w_ldreg), .ld_flags(w_ldfl), .mem_rd(w_rd), .mem_wr(w_wr),
    .mem_ack(w_ack), .dado_mem(w_dm), .endereco_mem(w_addr),
    .dado_para_mem(w_wdata), .mem_req(w_req), .mem_we(w_we),
    .busy(w_busy), .ir_out(w_ir), .flags_out(w_flags)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic clr();
    {bus1_sel, bus2_sel, src_a, src_b, dst, alu_sel} = '0;
    {ld_pc, pc_inc, ld_ir, ld_mar, ld_reg, ld_flags} = '0;
    {mem_rd, mem_wr, mem_ack} = '0;
    dado_mem = '0;
  endtask

  // Reference ALU: plain integer arithmetic on unsigned/signed interpretations.
  task automatic alu_ref(input int op, input int a, input int b, input int w,
                         output int res, output logic [3:0] fl);
    int m, smax, smin, sa, sb, t;
    logic c, v;
    m    = (1 << w) - 1;
    smax = (1 << (w - 1)) - 1;
    smin = -(1 << (w - 1));
    sa   = (a > smax) ? a - (1 << w) : a;
    sb   = (b > smax) ? b - (1 << w) : b;
    c = 0; v = 0;
    case (op)
      0: begin t = a + b; res = t & m; c = (t > m);  v = (sa + sb > smax) || (sa + sb < smin); end
      1: begin res = (a - b) & m; c = (a < b);        v = (sa - sb > smax) || (sa - sb < smin); end
      2: res = a & b;
      3: res = a | b;
      4: res = a ^ b;
      5: res = m - a;
      6: begin res = (a * 2) & m; c = (a > smax); end
      7: begin res = a / 2;       c = (a % 2 == 1); end
      8: begin res = (a + 1) & m; c = (a == m);     v = (sa + 1 > smax); end
      9: begin res = (a - 1) & m; c = (a == 0);     v = (sa - 1 < smin); end
      default: res = a;
    endcase
    fl = {v, c, res >= (1 << (w - 1)), res == 0};
  endtask

  task automatic mem_read(input logic [7:0] val);
    mem_rd = 1'b1;
    step();
    mem_rd = 1'b0; mem_ack = 1'b1; dado_mem = val;
    step();
    mem_ack = 1'b0;
  endtask

  // Value enters through MDR, travels bus1 -> bus2 into R[idx].
  task automatic load_reg(input logic [1:0] idx, input logic [7:0] val);
    mem_read(val);
    bus1_sel = 2'd3; bus2_sel = 2'd1; dst = idx; ld_reg = 1'b1;
    step();
    ld_reg = 1'b0;
  endtask

  task automatic peek(input logic [1:0] b1, input logic [1:0] b2, input logic [1:0] idx,
                      output logic [7:0] v);
    bus1_sel = b1; bus2_sel = b2; src_a = idx; ld_ir = 1'b1;
    step();
    ld_ir = 1'b0;
    v = ir_out;
  endtask

  initial begin
    logic [7:0] v;
    int         a, b, op, res;
    logic [3:0] fl;

    clr();
    {w_b1, w_b2, w_sa, w_sb, w_dst, w_alu} = '0;
    {w_ldpc, w_inc, w_ldir, w_ldmar, w_ldreg, w_ldfl, w_rd, w_wr, w_ack} = '0;
    w_dm = '0;
    ld_pc = 1'b1; ld_ir = 1'b1; mem_rd = 1'b1;
    step(); step();
    check("rst_busy", busy, 0);
    check("rst_req", mem_req, 0);
    check("rst_outs", {endereco_mem, dado_para_mem, ir_out, flags_out}, 0);
    clr();
    #3 reset = 1'b1;
    step();

    // Signed overflow on 0x7F + 0x01
    load_reg(2'd1, 8'h7F);
    load_reg(2'd2, 8'h01);
    alu_sel = 4'd0; src_a = 2'd1; src_b = 2'd2; bus2_sel = 2'd0; dst = 2'd3;
    ld_reg = 1'b1; ld_flags = 1'b1;
    step();
    clr();
    check("add_flags", flags_out, 4'b1010);
    peek(2'd1, 2'd1, 2'd3, v);
    check("add_r3", v, 8'h80);

    for (int i = 0; i < 20; i++) begin
      a  = int'($urandom_range(0, 255));
      b  = int'($urandom_range(0, 255));
      op = int'($urandom_range(0, 15));
      load_reg(2'd1, 8'(a));
      load_reg(2'd2, 8'(b));
      alu_sel = 4'(op); src_a = 2'd1; src_b = 2'd2; bus2_sel = 2'd0; dst = 2'd3;
      ld_reg = 1'b1; ld_flags = 1'b1;
      step();
      clr();
      alu_ref(op, a, b, 8, res, fl);
      check($sformatf("rnd%0d_op%0d_flags", i, op), flags_out, fl);
      peek(2'd1, 2'd1, 2'd3, v);
      check($sformatf("rnd%0d_op%0d_res", i, op), v, res);
    end

    // PC wrap and ld_pc priority over pc_inc
    load_reg(2'd0, 8'hFF);
    bus1_sel = 2'd1; src_a = 2'd0; bus2_sel = 2'd1; ld_pc = 1'b1;
    step();
    clr();
    peek(2'd0, 2'd3, 2'd0, v);
    check("pc_plus1_wrap", v, 8'h00);
    pc_inc = 1'b1;
    step();
    clr();
    peek(2'd0, 2'd1, 2'd0, v);
    check("pc_inc_wrap", v, 8'h00);
    load_reg(2'd0, 8'h10);
    bus1_sel = 2'd1; src_a = 2'd0; bus2_sel = 2'd1; ld_pc = 1'b1; pc_inc = 1'b1;
    step();
    clr();
    peek(2'd0, 2'd1, 2'd0, v);
    check("pc_ld_priority", v, 8'h10);

    // Read with three wait cycles; MAR locked while busy
    load_reg(2'd0, 8'h20);
    bus1_sel = 2'd1; src_a = 2'd0; bus2_sel = 2'd1; ld_mar = 1'b1;
    step();
    clr();
    check("mar_load", endereco_mem, 8'h20);
    mem_rd = 1'b1;
    step();
    mem_rd = 1'b0;
    for (int k = 0; k < 3; k++) begin
      check($sformatf("rd_wait%0d", k), {mem_req, mem_we, busy}, 3'b101);
      bus2_sel = 2'd3; ld_mar = 1'b1;
      step();
      ld_mar = 1'b0;
    end
    check("rd_mar_locked", endereco_mem, 8'h20);
    mem_ack = 1'b1; dado_mem = 8'hA5;
    step();
    clr();
    check("rd_done", {mem_req, busy}, 2'b00);
    peek(2'd0, 2'd2, 2'd0, v);
    check("rd_mdr", v, 8'hA5);

    // Simultaneous read+write: write wins, MDR untouched, WDR stable
    load_reg(2'd1, 8'h3C);
    mem_read(8'h5A);
    bus1_sel = 2'd1; src_a = 2'd1; mem_rd = 1'b1; mem_wr = 1'b1;
    step();
    check("wr_state", {mem_req, mem_we, busy}, 3'b111);
    check("wr_data", dado_para_mem, 8'h3C);
    bus1_sel = 2'd3;
    step();
    mem_rd = 1'b0; mem_wr = 1'b0;
    check("wr_data_stable", dado_para_mem, 8'h3C);
    mem_ack = 1'b1;
    step();
    clr();
    check("wr_done", {mem_req, mem_we, busy}, 3'b000);
    mem_ack = 1'b1;
    step();
    clr();
    check("ack_in_idle", busy, 0);
    peek(2'd0, 2'd2, 2'd0, v);
    check("wr_mdr_kept", v, 8'h5A);

    // Reset mid-read, then a stray ack
    load_reg(2'd2, 8'h77);
    ld_flags = 1'b1; alu_sel = 4'd5; src_a = 2'd0;
    mem_rd = 1'b1;
    step();
    clr();
    check("pre_rst_busy", busy, 1);
    reset = 1'b0;
    #1;
    check("async_rst", {mem_req, mem_we, busy, endereco_mem, dado_para_mem, ir_out, flags_out}, 0);
    #2 reset = 1'b1;
    mem_ack = 1'b1; dado_mem = 8'hEE;
    step();
    clr();
    check("post_rst_idle", {mem_req, busy}, 2'b00);
    for (int r = 0; r < 4; r++) begin
      peek(2'd1, 2'd1, 2'(r), v);
      check($sformatf("post_rst_r%0d", r), v, 0);
    end
    peek(2'd0, 2'd2, 2'd0, v);
    check("post_rst_mdr", v, 0);

    // WIDTH=16, NREGS=8: SHL of 0x8000
    w_rd = 1'b1;
    step();
    w_rd = 1'b0; w_ack = 1'b1; w_dm = 16'h8000;
    step();
    w_ack = 1'b0;
    w_b2 = 2'd2; w_dst = 3'd7; w_ldreg = 1'b1;
    step();
    w_alu = 4'd6; w_sa = 3'd7; w_b2 = 2'd0; w_dst = 3'd0; w_ldfl = 1'b1;
    step();
    w_ldreg = 1'b0; w_ldfl = 1'b0;
    alu_ref(6, 32'h8000, 0, 16, res, fl);
    check("w16_shl_flags", w_flags, fl);
    check("w16_shl_flags_lit", w_flags, 4'b0101);
    w_b1 = 2'd1; w_sa = 3'd0; w_b2 = 2'd1; w_ldir = 1'b1;
    step();
    w_ldir = 1'b0;
    check("w16_shl_res", w_ir, 16'h0000);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/caminho_dados_param.md
CAMINHO_DADOS_PARAM -- requirements
Module: caminho_dados_param

Interface
REQ-001 Parameter WIDTH, default 8, data/address width in bits, SHALL be at least 4.
REQ-002 Parameter NREGS, default 4, general-register count, SHALL be a power of two and at least 2; RSEL = log2(NREGS).
REQ-003 Ports SHALL be as follows.
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low
- bus1_sel  in  2  0 PC, 1 R[src_a], 2 R[src_b], 3 MDR
- bus2_sel  in  2  0 alu_out, 1 bus1, 2 MDR, 3 PC+1
- alu_sel  in  4  ALU operation
- src_a, src_b, dst  in  RSEL  register-file indices
- ld_pc, pc_inc, ld_ir, ld_mar, ld_reg, ld_flags  in  1  load strobes
- mem_rd, mem_wr  in  1  start memory read/write
- mem_ack  in  1  memory completion
- dado_mem  in  WIDTH  memory read data
- endereco_mem  out  WIDTH  memory address
- dado_para_mem  out  WIDTH  memory write data
- mem_req, mem_we  out  1  request, write qualifier
- busy  out  1  transaction in progress
- ir_out  out  WIDTH  instruction register
- flags_out  out  4  {V,C,N,Z}

Function
REQ-004 The ALU SHALL take A=R[src_a] and B=R[src_b] and compute WIDTH-bit alu_out.
- Ops: 0 ADD, 1 SUB (A-B), 2 AND, 3 OR, 4 XOR, 5 NOT A, 6 SHL A by 1, 7 SHR A by 1 (logical), 8 INC A, 9 DEC A.
- Codes 10-15 pass A.
- Z = result zero; N = result MSB.
- C = carry out (ADD/INC), borrow (SUB/DEC), bit shifted out (SHL/SHR), otherwise 0.
- V = signed overflow (ADD/SUB/INC/DEC), otherwise 0.
REQ-005 bus1 and bus2 SHALL be combinational muxes per bus1_sel/bus2_sel; PC+1 SHALL wrap modulo 2^WIDTH.
REQ-006 On each rising edge, ld_ir SHALL load IR from bus2.
REQ-007 On each rising edge, ld_reg SHALL load R[dst] from bus2.
REQ-008 On each rising edge, ld_flags SHALL load the flag register from the current ALU flags; otherwise the flags hold.
REQ-009 ld_pc SHALL load PC from bus2; otherwise pc_inc SHALL increment PC with wrap (2^WIDTH-1 -> 0).
REQ-010 When ld_pc and pc_inc are asserted together, ld_pc SHALL take priority.
REQ-011 ld_mar SHALL load MAR from bus2 only while busy=0; while busy=1 it SHALL be ignored.
REQ-012 endereco_mem SHALL equal MAR.
REQ-013 Memory FSM states SHALL be IDLE, RD, WR.
- IDLE->WR on mem_wr; WDR <= bus1.
- IDLE->RD on mem_rd with mem_wr=0.
- When both are asserted, write SHALL win and the read SHALL be dropped.
REQ-014 In RD or WR, mem_req SHALL be 1 and busy SHALL be 1; mem_we SHALL be 1 only in WR.
REQ-015 RD->IDLE on mem_ack, with MDR <= dado_mem on that edge; WR->IDLE on mem_ack.
- Minimum transaction is 2 cycles: request edge, then ack edge.
REQ-016 mem_rd/mem_wr while busy=1 SHALL be ignored and not queued; mem_ack in IDLE SHALL be ignored.
REQ-017 dado_para_mem SHALL equal WDR and SHALL stay stable while in WR.
REQ-018 Register, IR, PC and flag loads SHALL remain legal while busy=1.
REQ-019 R[dst] writes SHALL be visible on bus1 the cycle after the write; there is no bypass.

Reset
REQ-020 reset=0 SHALL asynchronously clear PC, IR, MAR, MDR, WDR, all R[i] and flags to 0.
- FSM SHALL go to IDLE; mem_req, mem_we and busy SHALL be 0.
- This SHALL apply mid-transaction; a mem_ack arriving after reset SHALL be ignored.
REQ-021 State SHALL change only on the first rising clock edge after reset deasserts.

Verification (WIDTH=8, NREGS=4 unless stated)
REQ-022 Load R1=0x7F and R2=0x01 via bus1; alu_sel=0, ld_reg dst=3, ld_flags -> R3=0x80, flags V=1, N=1, C=0, Z=0.
REQ-023 PC=0xFF, pc_inc -> PC=0x00; assert ld_pc with bus2=0x10 and pc_inc together -> PC=0x10.
REQ-024 MAR=0x20, mem_rd, ack after 3 wait cycles with dado_mem=0xA5.
- Required: mem_req=1, mem_we=0 and busy=1 for those cycles.
- Required: MDR=0xA5 and busy=0 on the cycle after ack.
- Required: ld_mar asserted during the wait leaves MAR=0x20.
REQ-025 mem_rd and mem_wr together with bus1=0x3C -> WR state, mem_we=1, dado_para_mem=0x3C; MDR unchanged.
REQ-026 Drop reset during RD, then deliver mem_ack -> all registers 0, mem_req=0, FSM stays IDLE.
REQ-027 WIDTH=16, NREGS=8: R7=0x8000, SHL -> result 0x0000, Z=1, C=1.
